// File: rtl/fifo_access_arbiter_pkg.sv
// Shared types and constants for the FIFO access arbiter.
package fifo_arb_pkg;

  localparam int FIFO_DEPTH = 16;
  localparam int FIFO_DW    = 8;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_WR,
    OP_RD
  } op_t;

endpackage

// File: rtl/fifo_access_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr_i, wrapping modulo N.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o
);

  logic [PW:0]   sum;
  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, ptr_i} + (PW+1)'(i);
      if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
      idx = sum[PW-1:0];
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_access_arbiter.sv
// Shares a single-op-per-cycle FIFO port between NUM_WR round-robin writers and one reader.
// Define FIFO_ARB_STARVE_GUARD_EN to force a read after STARVE_LIMIT consecutive contended writes.
module fifo_access_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_WR       = 4,
  parameter int DW           = FIFO_DW,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_WR-1:0]    wr_req_i,
  input  logic [NUM_WR*DW-1:0] wr_data_i,
  output logic [NUM_WR-1:0]    wr_gnt_o,
  input  logic                 rd_req_i,
  output logic                 rd_gnt_o,
  output logic                 rd_valid_o,
  output logic [DW-1:0]        rd_data_o,
  output logic                 fifo_wr_o,
  output logic                 fifo_rd_o,
  output logic [DW-1:0]        fifo_din_o,
  input  logic [DW-1:0]        fifo_dout_i,
  input  logic                 fifo_full_i,
  input  logic                 fifo_empty_i
);

  localparam int PW = $clog2(NUM_WR);

  if (NUM_WR < 2 || NUM_WR > 8 || STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_param
    $error("fifo_access_arbiter: NUM_WR or STARVE_LIMIT out of range");
  end

  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic              rd_valid_q, rd_valid_d;
  logic [NUM_WR-1:0] rr_gnt;
  logic              wr_elig, rd_elig, rd_first;
  op_t               op;

  rr_arbiter #(
    .N  (NUM_WR),
    .PW (PW)
  ) u_rr (
    .req_i (wr_req_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (rr_gnt)
  );

  assign wr_elig = (|wr_req_i) && !fifo_full_i;
  assign rd_elig = rd_req_i && !fifo_empty_i;

`ifdef FIFO_ARB_STARVE_GUARD_EN
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  assign rd_first = rd_elig && (starve_cnt_q == CNT_W'(STARVE_LIMIT));

  // Counts only writes that actually held off an eligible read.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!rd_elig || op == OP_RD) starve_cnt_d = '0;
    else if (op == OP_WR)        starve_cnt_d = starve_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) starve_cnt_q <= '0;
    else     starve_cnt_q <= starve_cnt_d;
  end
`else
  assign rd_first = 1'b0;
`endif

  always_comb begin
    op = OP_NONE;
    if (!rst) begin
      if (wr_elig && !rd_first) op = OP_WR;
      else if (rd_elig)         op = OP_RD;
    end
  end

  always_comb begin
    wr_gnt_o   = '0;
    fifo_din_o = '0;
    rr_ptr_d   = rr_ptr_q;
    if (op == OP_WR) begin
      wr_gnt_o = rr_gnt;
      for (int k = 0; k < NUM_WR; k++) begin
        if (rr_gnt[k]) begin
          fifo_din_o = wr_data_i[k*DW +: DW];
          rr_ptr_d   = (k == NUM_WR-1) ? '0 : PW'(k + 1);
        end
      end
    end
  end

  assign fifo_wr_o  = (op == OP_WR);
  assign fifo_rd_o  = (op == OP_RD);
  assign rd_gnt_o   = fifo_rd_o;
  assign rd_valid_d = fifo_rd_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_valid_q ? fifo_dout_i : '0;

endmodule

// File: doc/fifo_access_arbiter.md
# fifo_access_arbiter

Front-end controller for the 16-entry, 8-bit synchronous FIFO. It shares the FIFO's single-operation-per-cycle port between NUM_WR write requesters and one read requester. Writers are served round-robin. Reads are served when no write is issued, and, when the starvation guard is enabled, after a bounded run of writes. The block issues at most one of fifo_wr/fifo_rd per cycle, so the FIFO's write-over-read priority never silently drops a read.

## Interface
- NUM_WR, 4, number of write requesters (2..8)
- DW, 8, data width; must match the FIFO
- STARVE_LIMIT, 4, maximum consecutive write grants while a read is eligible (1..15)
- clk  in  1  clock; all state updates on the posedge
- rst  in  1  reset, synchronous, active-high
- wr_req  in  NUM_WR  level request per writer; data held until granted
- wr_data  in  NUM_WR*DW  writer i data at bits [i*DW +: DW]
- wr_gnt  out  NUM_WR  one-hot, combinational; data accepted this cycle
- rd_req  in  1  level request, one byte per rd_gnt
- rd_gnt  out  1  combinational; pop issued this cycle
- rd_valid  out  1  registered; rd_data valid this cycle
- rd_data  out  DW  fifo_dout when rd_valid, else 0
- fifo_wr, fifo_rd  out  1  FIFO controls; never both high
- fifo_din  out  DW  data of the granted writer, 0 when no write
- fifo_dout  in  DW  FIFO read data
- fifo_full, fifo_empty  in  1  FIFO flags

## Operation
- **Write eligibility:** a write is eligible when any wr_req is high and !fifo_full.
- **Read eligibility:** a read is eligible when rd_req is high and !fifo_empty.
- **Op selection, once per cycle:**
  - If only one class is eligible, serve that class.
  - If both are eligible, serve the write, except when the guard fires (see Configuration).
  - Otherwise issue no operation.
- **Round-robin writes:**
  - Search starts at rr_ptr and wraps modulo NUM_WR.
  - On each write grant to index k, rr_ptr becomes (k+1) mod NUM_WR.
  - rr_ptr holds when no write is granted.
- **Grant outputs:**
  - wr_gnt[k] = fifo_wr.
  - fifo_din = wr_data[k].
  - rd_gnt = fifo_rd.
- **Read return:** rd_valid <= fifo_rd. In the following cycle, rd_data = fifo_dout.
- **Reset:** while rst is high, all grants and fifo_wr/fifo_rd are forced to 0.
- **Reset values:**
  - Registers after rst: rr_ptr=0, starve_cnt=0, rd_valid=0.
  - Derived outputs after rst: rd_data=0, wr_gnt=0, rd_gnt=0, fifo_din=0.

## Timing
- **Write:** zero-cycle grant. The entry is in the FIFO after the same clock edge.
- **Read:** rd_gnt in cycle N gives rd_valid and data in cycle N+1.
- **Back-to-back reads:** one byte per cycle.
- **Full:** with fifo_full=1, wr_gnt stays 0. Reads still proceed, and a write may be granted the cycle after a pop.
- **Empty:** with fifo_empty=1, rd_gnt stays 0.
- **rst in cycle N+1 after a grant in N:** rd_valid is still 1 in N+1 (registered) and clears at the edge ending that cycle.

## Configuration
- **Macro:** FIFO_ARB_STARVE_GUARD_EN.
- **Defined:**
  - starve_cnt (4 bits) increments on each write grant while a read is eligible.
  - starve_cnt clears on a read grant, or in any cycle where no read is eligible.
  - When starve_cnt == STARVE_LIMIT and a read is eligible, the read is served instead of the write, and starve_cnt clears.
- **Undefined:** strict write priority. starve_cnt is absent, and reads are served only in cycles with no eligible write.

## Structure
- **Package fifo_arb_pkg:**
  - FIFO_DEPTH=16
  - DW default
  - op_t enum {OP_NONE, OP_WR, OP_RD}
- **Sub-module rr_arbiter:**
  - Parameterised on N.
  - Inputs req and ptr, output one-hot gnt.
  - Pure combinational.
  - fifo_access_arbiter owns rr_ptr and op selection.

## Test plan
- Writer 1 requests 0xA5 alone, then rd_req → wr_gnt=4'b0010 and fifo_din=0xA5 same cycle; rd_gnt next eligible cycle; rd_valid=1 and rd_data=0xA5 one cycle later.
- All 4 writers request continuously from reset, rd_req=0 → grants to writers 0,1,2,3,0,1,… one per cycle until full.
- 16 writes fill the FIFO, writer 2 keeps requesting → fifo_full=1, wr_gnt=0, fifo_wr=0. One pop then lets writer 2 be granted in the following cycle.
- rd_req=1 with an empty FIFO → rd_gnt=0 and rd_valid=0. The first write is followed by rd_gnt in the next cycle.
- Guard on, STARVE_LIMIT=4, writers saturate a non-empty non-full FIFO with rd_req=1 → repeating pattern of 4 write grants, 1 read grant. Guard off → zero read grants until writers stop.
- rst asserted mid-stream after grants to writer 2 → all grants 0 during rst; rd_valid=0 after the rst edge; first grant after release goes to writer 0.
